// File: rtl/fetch_stream.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stream
// Purpose  : Instruction fetch unit. Assembles instructions from memory beats,
//            most-significant beat first, and queues them with their PCs.
// Revision : 1.0
// ============================================================================
module fetch_stream #(
    parameter int                    MEM_WIDTH  = 8,
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [MEM_WIDTH-1:0]  i_mem_data,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_req,
    output logic                  o_mem_write,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_inst_pc,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int c_beats   = INST_WIDTH / MEM_WIDTH;
    localparam int c_bstep   = MEM_WIDTH / 8;
    localparam int c_beat_w  = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH + 1);
    localparam int c_align_w = $clog2(INST_WIDTH / 8);

    localparam logic [c_beat_w-1:0]   c_last_beat  = c_beat_w'(c_beats - 1);
    localparam logic [ADDR_WIDTH-1:0] c_inst_bytes = ADDR_WIDTH'(INST_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] c_bstep_a    = ADDR_WIDTH'(c_bstep);
    localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~(ADDR_WIDTH'((1 << c_align_w) - 1));
    localparam logic [c_ptr_w-1:0]    c_ptr_last   = c_ptr_w'(FIFO_DEPTH - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_full   = c_cnt_w'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [c_beat_w-1:0]   r_beat;
    logic [INST_WIDTH-1:0] r_asm;

    logic [INST_WIDTH-1:0] r_fifo_inst [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic                  w_last;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_req;
    logic                  w_push;
    logic [INST_WIDTH-1:0] w_merged;
    logic [c_ptr_w-1:0]    w_wr_ptr_nxt;
    logic [c_ptr_w-1:0]    w_rd_ptr_nxt;

    assign w_last = (r_beat == c_last_beat);
    assign w_full = (r_count == c_cnt_full);
    assign w_pop  = (r_count != '0) && i_ready;
    // The last beat may only be taken when its instruction has somewhere to go.
    assign w_req  = i_rst_n && !i_redirect && (!w_last || !w_full || w_pop);
    assign w_push = w_req && w_last;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_merged = r_asm;
        for (int b = 0; b < c_beats; b++) begin
            if (r_beat == c_beat_w'(b)) begin
                w_merged[(c_beats - b) * MEM_WIDTH - 1 -: MEM_WIDTH] = i_mem_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc     <= RESET_PC;
            r_beat   <= '0;
            r_asm    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_inst[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (i_redirect) begin
            r_pc     <= i_redirect_pc & c_align_mask;
            r_beat   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_req) begin
                r_asm <= w_merged;
                if (w_last) begin
                    r_beat <= '0;
                    r_pc   <= r_pc + c_inst_bytes;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            if (w_push) begin
                r_fifo_inst[r_wr_ptr] <= w_merged;
                r_fifo_pc[r_wr_ptr]   <= r_pc;
                r_wr_ptr              <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_mem_addr  = r_pc + (ADDR_WIDTH'(r_beat) * c_bstep_a);
    assign o_mem_req   = w_req;
    assign o_mem_write = 1'b0;
    assign o_inst      = r_fifo_inst[r_rd_ptr];
    assign o_inst_pc   = r_fifo_pc[r_rd_ptr];
    assign o_valid     = (r_count != '0);

endmodule
`default_nettype wire
